delay_scheduler: RTL and testbench
==================================

// Module: delay_scheduler
// PURPOSE
//   Shares one programmable delay timer among N_REQ requesters.
//   A round-robin arbiter grants the timer to one requester at a time.
//   The FSM loads that requester's delay, counts it out, then pulses that requester's done line.
//   Sits above delay-action style timing logic; exports the live count for waveform and debug.
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   CNT_W  4  delay/counter width; max delay = 2**CNT_W-1 cycles
// PORTS
//   clk          in   1            system clock, all logic on rising edge
//   rst          in   1            synchronous reset, active-low
//   req          in   N_REQ        level request per requester
//   delay_in     in   N_REQ*CNT_W  delay per requester; slice i = [i*CNT_W +: CNT_W]
//   gnt          out  N_REQ        one-hot grant, held for the whole operation
//   done         out  N_REQ        one-cycle completion pulse to the granted requester
//   busy         out  1            high whenever FSM != IDLE
//   out          out  1            one-cycle pulse on any completion (= |done)
//   out_counter  out  CNT_W        live timer count
// BEHAVIOUR
// - Reset (rst==0 at a rising edge), applies from any state, including mid-operation:
//   - state=IDLE; gnt=0, done=0, out=0, busy=0, out_counter=0.
//   - RR pointer reset so req[0] has highest priority.
//   - Any in-flight operation is aborted; no done pulse.
// - All outputs are registered.
// - FSM states: IDLE, LOAD, COUNT, DONE.
// - IDLE:
//   - If req!=0: choose the first set bit scanning from ptr+1 (mod N_REQ); after reset the scan starts at bit 0.
//   - Set gnt one-hot to the winner; go to LOAD.
//   - If req==0: stay in IDLE.
// - LOAD:
//   - target <= delay_in slice of the winner, sampled this cycle only; out_counter <= 0.
//   - If the sampled delay==0, go to DONE; otherwise go to COUNT.
// - COUNT:
//   - out_counter increments by 1 each cycle.
//   - When out_counter==target-1, go to DONE.
//   - COUNT lasts exactly target cycles. Max count shown is 2**CNT_W-2, so there is no wrap.
// - DONE:
//   - done[winner]=1 and out=1 for exactly one cycle.
//   - ptr <= winner; out_counter holds its last value; go to IDLE.
// - gnt stays asserted from LOAD through DONE inclusive, and clears in IDLE.
// - Latency: with D = sampled delay, done rises D+1 cycles after gnt rises.
//   - D=0 gives 1 cycle; D=15 gives 16 cycles.
// - Back-to-back operations are separated by one IDLE cycle (gnt low for exactly 1 cycle).
// - Requests are not preemptive:
//   - req and delay_in changes after LOAD are ignored.
//   - A dropped req does not abort the operation; done still pulses.
// - A req still high in IDLE after its done is re-arbitrated at lowest priority (round-robin).
// - Simultaneous requests: exactly one grant; never more than one gnt/done bit set.
// - busy = (state!=IDLE).
// TESTING
// 1. rst=0 for 2 cycles with req=4'b1111
//    -> gnt=0, done=0, busy=0, out=0, out_counter=0 throughout.
// 2. req=4'b0100, delay[2]=5
//    -> gnt=4'b0100 next cycle; out_counter 0,1,2,3,4;
//       done=4'b0100 pulses once, 6 cycles after gnt rises.
// 3. req=4'b1111 held, all delays=3
//    -> grant order 0,1,2,3,0; each done 4 cycles after its gnt;
//       1-cycle gnt gap between operations.
// 4. Boundaries: delay[1]=0 -> done[1] 1 cycle after gnt;
//    delay[3]=15 -> done[3] 16 cycles after gnt, out_counter peaks at 14.
// 5. rst=0 while COUNT with out_counter=3
//    -> next cycle all outputs 0, IDLE, no done pulse;
//       after release with req=4'b1001, gnt=4'b0001.
// 6. req[1] dropped mid-COUNT and delay_in[1] changed
//    -> operation runs the originally loaded delay; done[1] still pulses.

Source files
------------

// File: rtl/delay_scheduler_if.sv
// ---------------------------------------------------------------------------
// delay_scheduler_if
//   Bundles the requester-side signals of the shared delay timer.
//   master : requester side (drives req / delay_in, observes results)
//   slave  : the scheduler (samples req / delay_in, drives results)
// Signals
//   req          N_REQ        level request per requester
//   delay_in     N_REQ*CNT_W  delay per requester, slice i = [i*CNT_W +: CNT_W]
//   gnt          N_REQ        one-hot grant, held for the whole operation
//   done         N_REQ        one-cycle completion pulse to the granted requester
//   busy         1            scheduler is not idle
//   out          1            one-cycle pulse on any completion
//   out_counter  CNT_W        live timer count
// ---------------------------------------------------------------------------
interface delay_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] delay_in;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   out;
    logic [CNT_W-1:0]       out_counter;

    modport master (
        output req, delay_in,
        input  gnt, done, busy, out, out_counter
    );

    modport slave (
        input  req, delay_in,
        output gnt, done, busy, out, out_counter
    );
endinterface

// File: rtl/delay_scheduler.sv
// ---------------------------------------------------------------------------
// delay_scheduler
//   Shares one programmable delay timer among N_REQ requesters. A round-robin
//   arbiter picks one requester, the FSM loads that requester's delay, counts
//   it out and pulses the requester's done line. All outputs are registered.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-low (aborts any operation, no done)
//   bus  : delay_scheduler_if.slave (req, delay_in in; gnt, done, busy,
//          out, out_counter out)
// ---------------------------------------------------------------------------
module delay_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    delay_scheduler_if.slave     bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;      // last served requester
    logic [IDX_W-1:0]   win_q;      // requester currently owning the timer
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic               busy_q;
    logic               out_q;

    logic               found_d;
    logic [IDX_W-1:0]   pick_d;
    logic [CNT_W-1:0]   load_delay_d;
    int                 arb_idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin scan: start one past the last winner and wrap, so a
    // requester that was just served drops to lowest priority. Resetting
    // ptr to N_REQ-1 makes the first scan start at bit 0.
    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        arb_idx = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= N_REQ) begin
                arb_idx = arb_idx - N_REQ;
            end
            if (!found_d && bus.req[arb_idx]) begin
                found_d = 1'b1;
                pick_d  = IDX_W'(arb_idx);
            end
        end
    end

    // Delay slice of the current winner; only consumed in LOAD.
    always_comb begin
        load_delay_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_q == IDX_W'(i)) begin
                load_delay_d = bus.delay_in[i*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= IDX_W'(N_REQ - 1);
            win_q    <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= '0;
                    out_q  <= 1'b0;
                    if (found_d) begin
                        win_q   <= pick_d;
                        gnt_q   <= onehot(pick_d);
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    target_q <= load_delay_d;
                    cnt_q    <= '0;
                    if (load_delay_d == '0) begin
                        done_q  <= onehot(win_q);
                        out_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    // Leaving at target-1 makes COUNT last exactly target
                    // cycles and keeps the count below the wrap point.
                    if (cnt_q == target_q - CNT_W'(1)) begin
                        done_q  <= onehot(win_q);
                        out_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= '0;
                    out_q   <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= win_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.out         = out_q;
    assign bus.out_counter = cnt_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// ---------------------------------------------------------------------------
// tb_delay_scheduler
//   Self-checking bench for delay_scheduler (N_REQ=4, CNT_W=4): a cycle
//   table for reset and a single operation, then hand-written sequences for
//   round-robin order, delay boundaries, mid-operation reset and
//   non-preemption.
// ---------------------------------------------------------------------------
module tb_delay_scheduler;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    delay_scheduler_if #(.N_REQ(4), .CNT_W(4)) bus ();

    delay_scheduler #(.N_REQ(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [15:0] dly;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic        out;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.gnt != 4'd0) break;
        end
    endtask

    task automatic wait_done(output int n, output int peak);
        n = 0;
        peak = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (int'(bus.out_counter) > peak) peak = int'(bus.out_counter);
            if (bus.done != 4'd0) break;
        end
    endtask

    task automatic run_op(input int w, input int d, input int peak_exp, input int gap_exp);
        int g;
        int n;
        int pk;
        wait_gnt(g);
        chk("gap", g, gap_exp);
        chk("gnt", int'(bus.gnt), 1 << w);
        wait_done(n, pk);
        chk("latency", n, d + 1);
        chk("done", int'(bus.done), 1 << w);
        chk("out", int'(bus.out), 1);
        chk("gnt_hold", int'(bus.gnt), 1 << w);
        chk("peak", pk, peak_exp);
    endtask

    initial begin
        int g;
        int n;
        int pk;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.req      = 4'h0;
        bus.delay_in = 16'h0;

        // rst_n req dly       gnt   done  busy  out   cnt
        tbl[0]  = '{1'b0, 4'hF, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 4'hF, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 4'h0, 16'h0500, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 4'h4, 16'h0500, 4'h4, 4'h0, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 1'b0, 4'd1};
        tbl[6]  = '{1'b1, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 1'b0, 4'd2};
        tbl[7]  = '{1'b1, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 1'b0, 4'd3};
        tbl[8]  = '{1'b1, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 1'b0, 4'd4};
        tbl[9]  = '{1'b1, 4'h0, 16'h0500, 4'h4, 4'h4, 1'b1, 1'b1, 4'd4};
        tbl[10] = '{1'b1, 4'h0, 16'h0500, 4'h0, 4'h0, 1'b0, 1'b0, 4'd4};
        tbl[11] = '{1'b1, 4'h0, 16'h0500, 4'h0, 4'h0, 1'b0, 1'b0, 4'd4};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            rst          = tbl[i].rst_n;
            bus.req      = tbl[i].req;
            bus.delay_in = tbl[i].dly;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_gnt", i),  int'(bus.gnt),         int'(tbl[i].gnt));
            chk($sformatf("v%0d_done", i), int'(bus.done),        int'(tbl[i].done));
            chk($sformatf("v%0d_busy", i), int'(bus.busy),        int'(tbl[i].busy));
            chk($sformatf("v%0d_out", i),  int'(bus.out),         int'(tbl[i].out));
            chk($sformatf("v%0d_cnt", i),  int'(bus.out_counter), int'(tbl[i].cnt));
        end

        // Round-robin with all requesters held high, delay 3 each.
        bus.req      = 4'hF;
        bus.delay_in = 16'h3333;
        do_reset();
        run_op(0, 3, 2, 1);
        run_op(1, 3, 2, 2);
        run_op(2, 3, 2, 2);
        run_op(3, 3, 2, 2);
        run_op(0, 3, 2, 2);
        bus.req = 4'h0;

        // Delay boundaries: zero and maximum.
        bus.delay_in = 16'h0000;
        do_reset();
        bus.req = 4'h2;
        run_op(1, 0, 0, 1);
        bus.req      = 4'h8;
        bus.delay_in = 16'hF000;
        run_op(3, 15, 14, 2);
        bus.req = 4'h0;

        // Reset in the middle of COUNT.
        bus.req      = 4'h1;
        bus.delay_in = 16'h0008;
        do_reset();
        wait_gnt(g);
        chk("rst_mid_gnt", int'(bus.gnt), 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_cnt3", int'(bus.out_counter), 3);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_gnt0", int'(bus.gnt), 0);
        chk("rst_mid_done0", int'(bus.done), 0);
        chk("rst_mid_busy0", int'(bus.busy), 0);
        chk("rst_mid_out0", int'(bus.out), 0);
        chk("rst_mid_cnt0", int'(bus.out_counter), 0);
        rst     = 1'b1;
        bus.req = 4'h9;
        @(posedge clk);
        #1;
        chk("rst_rel_gnt", int'(bus.gnt), 1);
        bus.req = 4'h0;
        wait_done(n, pk);
        chk("rst_rel_done", int'(bus.done), 1);

        // Request dropped and delay changed after LOAD.
        bus.req      = 4'h2;
        bus.delay_in = 16'h0060;
        do_reset();
        wait_gnt(g);
        chk("np_gnt", int'(bus.gnt), 2);
        @(posedge clk);
        #1;
        bus.req      = 4'h0;
        bus.delay_in = 16'h0020;
        wait_done(n, pk);
        chk("np_latency", n + 1, 7);
        chk("np_done", int'(bus.done), 2);
        chk("np_peak", pk, 5);
        @(posedge clk);
        #1;
        chk("np_idle_gnt", int'(bus.gnt), 0);
        chk("np_idle_busy", int'(bus.busy), 0);
        chk("np_idle_done", int'(bus.done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
